// File: rtl/wallace_mul_pkg.sv
// Shared types and default sizing for the iterative digit multiplier and the modexp top.
package wallace_mul_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_DONE
   } mul_state_t;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_DIGIT = 8;

endpackage

// File: rtl/digit_mul.sv
// Combinational DIGIT x DIGIT unsigned multiplier, full 2*DIGIT-bit product.
module digit_mul #(
   parameter int unsigned DIGIT = 8
) (
   input  logic [DIGIT-1:0]   a,
   input  logic [DIGIT-1:0]   b,
   output logic [2*DIGIT-1:0] p
);

   // Sum of shifted partial-product rows; synthesis rebalances into a compressor tree.
   always_comb begin
      p = '0;
      for (int k = 0; k < DIGIT; k++) begin
         if (b[k]) begin
            p = p + ({{DIGIT{1'b0}}, a} << k);
         end
      end
   end

endmodule

// File: rtl/wallace_seq_mul.sv
// Iterative unsigned WIDTH x WIDTH multiplier: one shared digit multiplier, N*N accumulate
// cycles per product, valid/ready handshake on both sides.
module wallace_seq_mul
   import wallace_mul_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DIGIT = DEF_DIGIT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_c,
   output logic               busy
);

   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned W2 = 2 * WIDTH;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if (WIDTH % DIGIT != 0) begin : g_bad_digit
         $error("wallace_seq_mul: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   mul_state_t       state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [W2-1:0]    acc;
   logic [W2-1:0]    c_q;
   logic [CW-1:0]    i;
   logic [CW-1:0]    j;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   logic [DIGIT-1:0]   dig_a;
   logic [DIGIT-1:0]   dig_b;
   logic [2*DIGIT-1:0] prod;
   logic [31:0]        shamt;
   logic [W2-1:0]      pp;
   logic [W2-1:0]      sum;

   always_comb begin
      dig_a = '0;
      dig_b = '0;
      for (int k = 0; k < N; k++) begin
         if (i == CW'(k)) dig_a = a_q[k*DIGIT +: DIGIT];
         if (j == CW'(k)) dig_b = b_q[k*DIGIT +: DIGIT];
      end
   end

   digit_mul #(
      .DIGIT (DIGIT)
   ) u_digit_mul (
      .a (dig_a),
      .b (dig_b),
      .p (prod)
   );

   always_comb begin
      shamt = (32'(i) + 32'(j)) * DIGIT;
      pp    = W2'(prod) << shamt;
      sum   = acc + pp;
   end

   // Handshake flags are registered alongside the state so they change only on clock edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc         <= '0;
         c_q         <= '0;
         i           <= '0;
         j           <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q        <= in_a;
                  b_q        <= in_b;
                  acc        <= '0;
                  i          <= '0;
                  j          <= '0;
                  state      <= ST_CALC;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ST_CALC: begin
               acc <= sum;
               if (j == LAST) begin
                  j <= '0;
                  if (i == LAST) begin
                     state       <= ST_DONE;
                     out_valid_q <= 1'b1;
                     c_q         <= sum;
                  end else begin
                     i <= i + 1'b1;
                  end
               end else begin
                  j <= j + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state       <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state       <= ST_IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_c     = c_q;

endmodule
